// File: rtl/axi_common.sv
// Shared AXI field types used by the write (and read) side arbiters.
// Pure type definitions; no logic.
package axi_common;

   typedef logic [1:0] burst_t;   // FIXED / INCR / WRAP
   typedef logic [3:0] cache_t;   // AxCACHE attributes
   typedef logic [2:0] prot_t;    // AxPROT attributes
   typedef logic [1:0] resp_t;    // OKAY / EXOKAY / SLVERR / DECERR

   localparam resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, searching cyclically.
//   req       in  [N]        request vector
//   ptr       in  [PW]       search start index (0..N-1)
//   gnt_idx   out [PW]       winning index (0 when nothing requests)
//   gnt_valid out 1          some request is set
module axi_rr_arbiter #(
   parameter int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] gnt_idx,
   output logic          gnt_valid
);

   logic [PW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is the last
   // assignment and therefore wins.
   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = PW'((int'(ptr) + i) % N);
         if (req[cand]) begin
            gnt_idx   = cand;
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write port (AW/W/B) between
// NumMasters masters. One burst at a time: AW beat, then W beats through
// WLAST. Slave-side ID is {master index, master ID}; B is routed back by
// that prefix. Accepted-but-unanswered bursts are capped at MaxOutstanding.
//   clk_i, rst_ni                       clock, async active-low reset
//   m_aw*_i / m_awready_o               per-master AW channel
//   m_w*_i  / m_wready_o                per-master W channel
//   m_b*_o  / m_bready_i                per-master B channel
//   s_aw*_o / s_awready_i               shared slave AW channel
//   s_w*_o  / s_wready_i                shared slave W channel
//   s_b*_i  / s_bready_o                shared slave B channel
module axi_write_arbiter
   import axi_common::*;
#(
   parameter int NumMasters     = 2,
   parameter int IdWidth        = 4,
   parameter int AddrWidth      = 64,
   parameter int DataWidth      = 64,
   parameter int MaxOutstanding = 8,
   localparam int SelWidth      = $clog2(NumMasters),
   localparam int StrbWidth     = DataWidth / 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   // master AW
   input  logic   [NumMasters-1:0]               m_awvalid_i,
   input  logic   [NumMasters-1:0][IdWidth-1:0]  m_awid_i,
   input  logic   [NumMasters-1:0][AddrWidth-1:0] m_awaddr_i,
   input  logic   [NumMasters-1:0][7:0]          m_awlen_i,
   input  logic   [NumMasters-1:0][2:0]          m_awsize_i,
   input  burst_t [NumMasters-1:0]               m_awburst_i,
   input  cache_t [NumMasters-1:0]               m_awcache_i,
   input  prot_t  [NumMasters-1:0]               m_awprot_i,
   output logic   [NumMasters-1:0]               m_awready_o,
   // master W
   input  logic   [NumMasters-1:0]               m_wvalid_i,
   input  logic   [NumMasters-1:0][DataWidth-1:0] m_wdata_i,
   input  logic   [NumMasters-1:0][StrbWidth-1:0] m_wstrb_i,
   input  logic   [NumMasters-1:0]               m_wlast_i,
   output logic   [NumMasters-1:0]               m_wready_o,
   // master B
   output logic   [NumMasters-1:0]               m_bvalid_o,
   output logic   [NumMasters-1:0][IdWidth-1:0]  m_bid_o,
   output resp_t  [NumMasters-1:0]               m_bresp_o,
   input  logic   [NumMasters-1:0]               m_bready_i,
   // slave AW
   output logic                                  s_awvalid_o,
   output logic   [IdWidth+SelWidth-1:0]         s_awid_o,
   output logic   [AddrWidth-1:0]                s_awaddr_o,
   output logic   [7:0]                          s_awlen_o,
   output logic   [2:0]                          s_awsize_o,
   output burst_t                                s_awburst_o,
   output cache_t                                s_awcache_o,
   output prot_t                                 s_awprot_o,
   input  logic                                  s_awready_i,
   // slave W
   output logic                                  s_wvalid_o,
   output logic   [DataWidth-1:0]                s_wdata_o,
   output logic   [StrbWidth-1:0]                s_wstrb_o,
   output logic                                  s_wlast_o,
   input  logic                                  s_wready_i,
   // slave B
   input  logic                                  s_bvalid_i,
   input  logic   [IdWidth+SelWidth-1:0]         s_bid_i,
   input  resp_t                                 s_bresp_i,
   output logic                                  s_bready_o
);

   localparam int CntWidth = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

   state_e                state_q, state_d;
   logic [SelWidth-1:0]   grant_q, ptr_q;
   logic [CntWidth-1:0]   outstanding_q;
   logic [SelWidth-1:0]   arb_idx;
   logic                  arb_valid;
   logic                  grant_load;
   logic                  aw_hs, b_hs;
   logic [SelWidth-1:0]   b_sel;
   logic [31:0]           b_sel_ext;

   axi_rr_arbiter #(.N(NumMasters)) u_arb (
      .req       (m_awvalid_i),
      .ptr       (ptr_q),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (grant_load) begin
            grant_q <= arb_idx;
            ptr_q   <= (arb_idx == SelWidth'(NumMasters - 1)) ? '0 : arb_idx + 1'b1;
         end
      end
   end

   // ---------------- next state / handshake steering ----------------
   always_comb begin
      state_d     = state_q;
      grant_load  = 1'b0;
      s_awvalid_o = 1'b0;
      s_wvalid_o  = 1'b0;
      m_awready_o = '0;
      m_wready_o  = '0;
      case (state_q)
         S_IDLE: begin
            // The cap is checked here only: one burst in flight at a time
            // means the counter can reach MaxOutstanding but never pass it.
            if (arb_valid && (outstanding_q < CntWidth'(MaxOutstanding))) begin
               grant_load = 1'b1;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            s_awvalid_o          = 1'b1;
            m_awready_o[grant_q] = s_awready_i;
            if (s_awready_i) state_d = S_DATA;
         end
         S_DATA: begin
            s_wvalid_o          = m_wvalid_i[grant_q];
            m_wready_o[grant_q] = s_wready_i;
            if (m_wvalid_i[grant_q] && s_wready_i && m_wlast_i[grant_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Payloads follow the registered grant, so they stay stable while valid.
   assign s_awid_o    = {grant_q, m_awid_i[grant_q]};
   assign s_awaddr_o  = m_awaddr_i[grant_q];
   assign s_awlen_o   = m_awlen_i[grant_q];
   assign s_awsize_o  = m_awsize_i[grant_q];
   assign s_awburst_o = m_awburst_i[grant_q];
   assign s_awcache_o = m_awcache_i[grant_q];
   assign s_awprot_o  = m_awprot_i[grant_q];
   assign s_wdata_o   = m_wdata_i[grant_q];
   assign s_wstrb_o   = m_wstrb_i[grant_q];
   assign s_wlast_o   = m_wlast_i[grant_q];

   // ---------------- B routing (purely combinational) ----------------
   assign b_sel     = s_bid_i[IdWidth +: SelWidth];
   assign b_sel_ext = 32'(b_sel);

   always_comb begin
      m_bvalid_o = '0;
      s_bready_o = 1'b1;  // unknown index: sink the response
      for (int m = 0; m < NumMasters; m++) begin
         m_bid_o[m]   = s_bid_i[IdWidth-1:0];
         m_bresp_o[m] = s_bresp_i;
      end
      if (b_sel_ext < 32'(NumMasters)) begin
         m_bvalid_o[b_sel] = s_bvalid_i;
         s_bready_o        = m_bready_i[b_sel];
      end
   end

   // ---------------- outstanding burst counter ----------------
   assign aw_hs = (state_q == S_ADDR) && s_awready_i;
   assign b_hs  = s_bvalid_i && s_bready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             outstanding_q <= '0;
      else if (aw_hs && !b_hs) outstanding_q <= outstanding_q + 1'b1;
      else if (b_hs && !aw_hs) outstanding_q <= outstanding_q - 1'b1;
   end

endmodule
